// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//
// Shares the single physical-memory port between the split instruction and
// data caches of the RV32I core. One transaction is in flight at a time: the
// winning request is latched in IDLE, held on the memory port until
// pmem_resp, and the returned line is handed back with a one-cycle resp
// pulse in RELEASE. The FSM state is exported on arbiter_state for debug.
//
// Build option:
//   CACHE_ARBITER_RR_EN  defined   -> round-robin tie-break using a 1-bit
//                                     last-owner register (resets to D, so
//                                     the icache wins the first tie).
//                        undefined -> fixed priority, dcache wins ties.
//
// Parameters:
//   LINE_W  cache line width in bits
//   ADDR_W  byte address width (must exceed 5)
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            synchronous active-low reset
//   i_read         icache line-fill request
//   i_addr         icache line address
//   i_rdata        line returned to icache (holds last fill)
//   i_resp         icache completion pulse
//   d_read         dcache line-fill request
//   d_write        dcache write-back request (wins over d_read)
//   d_addr         dcache line address
//   d_wdata        write-back line
//   d_rdata        line returned to dcache (holds last fill)
//   d_resp         dcache completion pulse
//   pmem_read      memory read strobe
//   pmem_write     memory write strobe
//   pmem_addr      memory address, low 5 bits forced to 0
//   pmem_wdata     memory write line
//   pmem_rdata     memory read line
//   pmem_resp      memory completion
//   arbiter_state  FSM state: 00 IDLE, 01 SERVE_I, 10 SERVE_D, 11 RELEASE
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [1:0]        arbiter_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10,
        RELEASE = 2'b11
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic                r_owner_d;
    logic [LINE_W-1:0]   r_i_rdata;
    logic [LINE_W-1:0]   r_d_rdata;
    logic                r_i_resp;
    logic                r_d_resp;
    logic                r_pmem_read;
    logic                r_pmem_write;

    logic                w_i_req;
    logic                w_d_req;
    logic                w_grant_d;
    logic [ADDR_W-1:0]   w_i_line_addr;
    logic [ADDR_W-1:0]   w_d_line_addr;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Line-align addresses at latch time so pmem_addr never carries offset bits.
    assign w_i_line_addr = {i_addr[ADDR_W-1:5], 5'b0_0000};
    assign w_d_line_addr = {d_addr[ADDR_W-1:5], 5'b0_0000};

`ifdef CACHE_ARBITER_RR_EN
    logic r_last_d;

    // On a tie the requester that did not own the previous grant wins.
    assign w_grant_d = w_d_req & ~(w_i_req & r_last_d);
`else
    assign w_grant_d = w_d_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_owner_d    <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
`ifdef CACHE_ARBITER_RR_EN
            r_last_d     <= 1'b1;
`endif
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_i_req || w_d_req) begin
                        if (w_grant_d) begin
                            r_addr       <= w_d_line_addr;
                            r_wdata      <= d_wdata;
                            r_owner_d    <= 1'b1;
                            r_pmem_write <= d_write;
                            r_pmem_read  <= ~d_write;
                            r_state      <= SERVE_D;
                        end else begin
                            // Write-data latch is left untouched on an icache grant.
                            r_addr       <= w_i_line_addr;
                            r_owner_d    <= 1'b0;
                            r_pmem_write <= 1'b0;
                            r_pmem_read  <= 1'b1;
                            r_state      <= SERVE_I;
                        end
`ifdef CACHE_ARBITER_RR_EN
                        r_last_d <= w_grant_d;
`endif
                    end
                end

                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (r_owner_d) begin
                            r_d_rdata <= pmem_rdata;
                            r_d_resp  <= 1'b1;
                        end else begin
                            r_i_rdata <= pmem_rdata;
                            r_i_resp  <= 1'b1;
                        end
                        r_state <= RELEASE;
                    end
                end

                RELEASE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata       = r_i_rdata;
    assign i_resp        = r_i_resp;
    assign d_rdata       = r_d_rdata;
    assign d_resp        = r_d_resp;
    assign pmem_read     = r_pmem_read;
    assign pmem_write    = r_pmem_write;
    assign pmem_addr     = r_addr;
    assign pmem_wdata    = r_wdata;
    assign arbiter_state = r_state;

endmodule
